// File: rtl/spi_apb_sequencer.sv
// spi_apb_sequencer: APB master that initialises a CoreSPI instance and then runs
// SPI transactions for NREQ fabric requesters under round-robin arbitration.
// For each granted request it selects the slave, streams len bytes (TXDATA write,
// wait for SPIRXAVAIL, RXDATA read), then deselects the slave.
//
// Ports
//   PCLK, PRESET      clock and synchronous active-high reset
//   req_valid/ready   per-requester request and one-cycle grant pulse
//   req_ss, req_len   slave index and byte count, sampled on grant (len 0 -> 1)
//   tx_data, tx_ack   per-requester TX byte and consume pulse
//   rx_data, rx_valid received byte (shared) and per-requester valid pulse
//   done, err, busy   completion pulse, abort flag with done, activity
//   M_P*              APB master port towards CoreSPI
//   SPIRXAVAIL        CoreSPI RX FIFO not empty
module spi_apb_sequencer #(
    parameter int unsigned NREQ        = 2,
    parameter logic [6:0]  ADDR_CTRL   = 7'h00,
    parameter logic [6:0]  ADDR_RXDATA = 7'h08,
    parameter logic [6:0]  ADDR_TXDATA = 7'h0C,
    parameter logic [6:0]  ADDR_SSEL   = 7'h24,
    parameter logic [7:0]  CTRL_INIT   = 8'h03,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_ss,
    input  logic [8*NREQ-1:0] req_len,
    input  logic [8*NREQ-1:0] tx_data,
    output logic [NREQ-1:0]   tx_ack,
    output logic [7:0]        rx_data,
    output logic [NREQ-1:0]   rx_valid,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic              busy,
    output logic [6:0]        M_PADDR,
    output logic              M_PSEL,
    output logic              M_PENABLE,
    output logic              M_PWRITE,
    output logic [7:0]        M_PWDATA,
    input  logic [7:0]        M_PRDATA,
    input  logic              M_PREADY,
    input  logic              M_PSLVERR,
    input  logic              SPIRXAVAIL
);

    localparam int unsigned IW = (NREQ > 2) ? 2 : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        StInitCtrl, StInitSsel, StIdle, StSel, StTx, StWaitRx, StRx, StDesel, StDone
    } state_e;

    state_e          state_q, state_d;
    logic            phase_q, phase_d;   // 0: APB setup cycle, 1: APB access cycle(s)
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [2:0]      ss_q, ss_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            abort_q, abort_d;

    logic            gnt_found;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   pos;
    logic [7:0]      gnt_len;
    logic            acc_done;

    // Round-robin search starting at rr_q.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        pos       = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            pos = IW'((int'(rr_q) + k) % int'(NREQ));
            if (!gnt_found && req_valid[pos]) begin
                gnt_found = 1'b1;
                gnt_idx   = pos;
            end
        end
    end

    assign gnt_len  = req_len[8*int'(gnt_idx) +: 8];
    // Only meaningful in APB states; phase_q is held low everywhere else.
    assign acc_done = phase_q & M_PREADY;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rr_d      = rr_q;
        ss_d      = ss_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        abort_d   = abort_q;
        M_PSEL    = 1'b0;
        M_PWRITE  = 1'b0;
        M_PADDR   = '0;
        M_PWDATA  = '0;
        req_ready = '0;
        tx_ack    = '0;
        rx_valid  = '0;
        rx_data   = '0;
        done      = '0;
        err       = 1'b0;

        unique case (state_q)
            StInitCtrl: begin
                M_PSEL   = 1'b1;
                M_PWRITE = 1'b1;
                M_PADDR  = ADDR_CTRL;
                M_PWDATA = CTRL_INIT;
                if (acc_done) state_d = StInitSsel;
            end
            StInitSsel: begin
                M_PSEL   = 1'b1;
                M_PWRITE = 1'b1;
                M_PADDR  = ADDR_SSEL;
                if (acc_done) state_d = StIdle;
            end
            StIdle: begin
                if (gnt_found) begin
                    req_ready[gnt_idx] = 1'b1;
                    idx_d   = gnt_idx;
                    ss_d    = req_ss[3*int'(gnt_idx) +: 3];
                    cnt_d   = (gnt_len == 8'd0) ? 8'd1 : gnt_len;
                    abort_d = 1'b0;
                    state_d = StSel;
                end
            end
            StSel: begin
                M_PSEL   = 1'b1;
                M_PWRITE = 1'b1;
                M_PADDR  = ADDR_SSEL;
                M_PWDATA = 8'h01 << ss_q;
                if (acc_done) begin
                    if (M_PSLVERR) begin
                        abort_d = 1'b1;
                        state_d = StDesel;
                    end else begin
                        state_d = StTx;
                    end
                end
            end
            StTx: begin
                M_PSEL   = 1'b1;
                M_PWRITE = 1'b1;
                M_PADDR  = ADDR_TXDATA;
                M_PWDATA = tx_data[8*int'(idx_q) +: 8];
                if (acc_done) begin
                    tx_ack[idx_q] = 1'b1;
                    tmo_d         = '0;
                    if (M_PSLVERR) begin
                        abort_d = 1'b1;
                        state_d = StDesel;
                    end else begin
                        state_d = StWaitRx;
                    end
                end
            end
            StWaitRx: begin
                if (SPIRXAVAIL) begin
                    state_d = StRx;
                end else if (tmo_q == TW'(TIMEOUT_CYC)) begin
                    abort_d = 1'b1;
                    state_d = StDesel;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StRx: begin
                M_PSEL  = 1'b1;
                M_PADDR = ADDR_RXDATA;
                if (acc_done) begin
                    if (M_PSLVERR) begin
                        abort_d = 1'b1;
                        state_d = StDesel;
                    end else begin
                        rx_valid[idx_q] = 1'b1;
                        rx_data         = M_PRDATA;
                        cnt_d           = cnt_q - 8'd1;
                        state_d         = (cnt_q == 8'd1) ? StDesel : StTx;
                    end
                end
            end
            StDesel: begin
                M_PSEL   = 1'b1;
                M_PWRITE = 1'b1;
                M_PADDR  = ADDR_SSEL;
                if (acc_done) state_d = StDone;
            end
            StDone: begin
                done[idx_q] = 1'b1;
                err         = abort_q;
                abort_d     = 1'b0;
                rr_d        = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StInitCtrl;
        endcase

        // Setup cycle always advances to access; access holds until PREADY.
        phase_d   = M_PSEL & (~phase_q | ~M_PREADY);
        M_PENABLE = M_PSEL & phase_q;

        // Outputs read as idle the whole time reset is applied.
        if (PRESET) begin
            M_PSEL    = 1'b0;
            M_PENABLE = 1'b0;
            M_PWRITE  = 1'b0;
            M_PADDR   = '0;
            M_PWDATA  = '0;
            req_ready = '0;
            tx_ack    = '0;
            rx_valid  = '0;
            rx_data   = '0;
            done      = '0;
            err       = 1'b0;
        end
    end

    assign busy = (state_q != StIdle) | gnt_found;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= StInitCtrl;
            phase_q <= 1'b0;
            idx_q   <= '0;
            rr_q    <= '0;
            ss_q    <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            ss_q    <= ss_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_spi_apb_sequencer.sv
// tb_spi_apb_sequencer: bench for spi_apb_sequencer with NREQ=2. A small APB slave
// model loops TXDATA back to RXDATA, and a monitor pops expected events (grants,
// APB completions, tx_ack, rx_valid, done) from a scoreboard queue.
module tb_spi_apb_sequencer;

    localparam int KGnt = 0, KWr = 1, KRd = 2, KTxAck = 3, KRxV = 4, KDone = 5;

    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    typedef struct {
        int         r;
        logic [2:0] ss;
        logic [7:0] len;
        logic [7:0] b0, b1, b2;
        logic [7:0] exp_ssel;
        int         exp_bytes;
    } vec_t;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [5:0]  req_ss = '0;
    logic [15:0] req_len = '0;
    logic [15:0] tx_data;
    logic [1:0]  tx_ack;
    logic [7:0]  rx_data;
    logic [1:0]  rx_valid;
    logic [1:0]  done;
    logic        err;
    logic        busy;
    logic [6:0]  M_PADDR;
    logic        M_PSEL, M_PENABLE, M_PWRITE;
    logic [7:0]  M_PWDATA;
    logic [7:0]  M_PRDATA;
    logic        M_PREADY;
    logic        M_PSLVERR = 1'b0;
    logic        SPIRXAVAIL;

    spi_apb_sequencer #(.NREQ(2)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_ss(req_ss), .req_len(req_len),
        .tx_data(tx_data), .tx_ack(tx_ack), .rx_data(rx_data), .rx_valid(rx_valid),
        .done(done), .err(err), .busy(busy),
        .M_PADDR(M_PADDR), .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE), .M_PWRITE(M_PWRITE),
        .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY),
        .M_PSLVERR(M_PSLVERR), .SPIRXAVAIL(SPIRXAVAIL)
    );

    always #5 PCLK = ~PCLK;

    // APB slave model with TX->RX loopback and optional TXDATA wait states.
    int         stall_tx = 0;
    int         wait_left = 0;
    logic       pending = 1'b0;
    logic       rxavail_en = 1'b1;
    logic [7:0] lb = '0;

    assign M_PREADY   = (wait_left == 0);
    assign M_PRDATA   = lb;
    assign SPIRXAVAIL = pending & rxavail_en;

    always @(posedge PCLK) begin
        if (PRESET) begin
            wait_left <= 0;
            pending   <= 1'b0;
        end else begin
            if (M_PSEL && !M_PENABLE) wait_left <= (M_PADDR == 7'h0C) ? stall_tx : 0;
            else if (M_PSEL && M_PENABLE && wait_left > 0) wait_left <= wait_left - 1;
            if (M_PSEL && M_PENABLE && M_PREADY) begin
                if (M_PWRITE && M_PADDR == 7'h0C) begin
                    lb      <= M_PWDATA;
                    pending <= 1'b1;
                end else if (!M_PWRITE && M_PADDR == 7'h08) begin
                    pending <= 1'b0;
                end
            end
        end
    end

    // Per-requester TX byte buffers, advanced on tx_ack.
    logic [7:0] txbuf [2][4];
    logic [1:0] tx_ptr [2];

    always @(posedge PCLK) begin
        for (int i = 0; i < 2; i++) begin
            if (PRESET || req_ready[i]) tx_ptr[i] <= '0;
            else if (tx_ack[i])         tx_ptr[i] <= tx_ptr[i] + 2'd1;
        end
    end

    always_comb begin
        tx_data = '0;
        for (int i = 0; i < 2; i++) tx_data[8*i +: 8] = txbuf[i][tx_ptr[i]];
    end

    int   checks = 0;
    int   errors = 0;
    int   tx_acc = 0;
    ev_t  exp_q[$];

    function automatic void chk(string name, logic [31:0] got, logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, expv);
        end
    endfunction

    function automatic void push_ev(int kind, int a, int b);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endfunction

    function automatic void observe(int kind, int a, int b);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d a=%0h b=%0h, required none", kind, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a != a || e.b != b) begin
                errors++;
                $display("FAIL event: got kind=%0d a=%0h b=%0h, required kind=%0d a=%0h b=%0h",
                         kind, a, b, e.kind, e.a, e.b);
            end
        end
    endfunction

    function automatic void push_txn(int r, logic [7:0] ssel, int n,
                                     logic [7:0] b0, logic [7:0] b1, logic [7:0] b2);
        logic [7:0] bk;
        push_ev(KGnt, r, 0);
        push_ev(KWr, 'h24, int'(ssel));
        for (int k = 0; k < n; k++) begin
            bk = (k == 0) ? b0 : (k == 1) ? b1 : b2;
            push_ev(KWr, 'h0C, int'(bk));
            push_ev(KTxAck, r, 0);
            push_ev(KRd, 'h08, int'(bk));
            push_ev(KRxV, r, int'(bk));
        end
        push_ev(KWr, 'h24, 0);
        push_ev(KDone, r, 0);
    endfunction

    task automatic monitor();
        logic prev_wait = 1'b0;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                prev_wait = 1'b0;
            end else begin
                for (int i = 0; i < 2; i++) if (req_ready[i]) observe(KGnt, i, 0);
                if (M_PSEL && M_PENABLE && M_PREADY)
                    observe(M_PWRITE ? KWr : KRd, int'(M_PADDR),
                            M_PWRITE ? int'(M_PWDATA) : int'(M_PRDATA));
                for (int i = 0; i < 2; i++) if (tx_ack[i]) observe(KTxAck, i, 0);
                for (int i = 0; i < 2; i++) if (rx_valid[i]) observe(KRxV, i, int'(rx_data));
                for (int i = 0; i < 2; i++) if (done[i]) observe(KDone, i, int'(err));
                if (prev_wait) chk("penable_hold", {30'd0, M_PSEL, M_PENABLE}, 32'd3);
                prev_wait = M_PSEL && M_PENABLE && !M_PREADY;
                if (M_PSEL && M_PENABLE && M_PADDR == 7'h0C) tx_acc++;
            end
        end
    endtask

    // which: 0 req_ready, 1 done, 2 tx_ack
    task automatic wait_bit(input int which, input int r, input int budget, input string name);
        logic hit = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge PCLK);
            if ((which == 0 && req_ready[r]) || (which == 1 && done[r]) ||
                (which == 2 && tx_ack[r])) begin
                hit = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, hit}, 32'd1);
    endtask

    task automatic hold_req(input int r, input int budget);
        req_valid[r] = 1'b1;
        wait_bit(0, r, budget, "grant_wait");
        @(posedge PCLK);
        #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic set_req(input int r, input logic [2:0] ss, input logic [7:0] len,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        req_ss[3*r +: 3]  = ss;
        req_len[8*r +: 8] = len;
        txbuf[r][0] = b0;
        txbuf[r][1] = b1;
        txbuf[r][2] = b2;
        txbuf[r][3] = 8'h00;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge PCLK);
            if (!busy) break;
            n++;
        end
    endtask

    vec_t vecs [4];
    int   n;
    int   acc0;

    initial begin
        vecs[0] = '{r: 0, ss: 3'd2, len: 8'd3, b0: 8'hA1, b1: 8'hB2, b2: 8'hC3,
                    exp_ssel: 8'h04, exp_bytes: 3};
        vecs[1] = '{r: 1, ss: 3'd7, len: 8'd1, b0: 8'h5A, b1: 8'h00, b2: 8'h00,
                    exp_ssel: 8'h80, exp_bytes: 1};
        vecs[2] = '{r: 0, ss: 3'd0, len: 8'd0, b0: 8'h3C, b1: 8'h00, b2: 8'h00,
                    exp_ssel: 8'h01, exp_bytes: 1};
        vecs[3] = '{r: 1, ss: 3'd5, len: 8'd2, b0: 8'hFF, b1: 8'h00, b2: 8'h00,
                    exp_ssel: 8'h20, exp_bytes: 2};
        for (int i = 0; i < 2; i++) for (int k = 0; k < 4; k++) txbuf[i][k] = 8'h00;

        fork
            monitor();
        join_none

        // Reset state and init sequence.
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("reset_outputs", {M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA, req_ready,
                              tx_ack, rx_valid, done, err, rx_data}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd1);
        push_ev(KWr, 'h00, 'h03);
        push_ev(KWr, 'h24, 'h00);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        count_busy(n);
        chk("init_cycles", n, 32'd4);
        chk("init_queue_empty", exp_q.size(), 32'd0);

        // Table-driven single-requester transactions.
        for (int v = 0; v < 4; v++) begin
            set_req(vecs[v].r, vecs[v].ss, vecs[v].len, vecs[v].b0, vecs[v].b1, vecs[v].b2);
            push_txn(vecs[v].r, vecs[v].exp_ssel, vecs[v].exp_bytes,
                     vecs[v].b0, vecs[v].b1, vecs[v].b2);
            @(posedge PCLK);
            #1;
            hold_req(vecs[v].r, 20);
            wait_bit(1, vecs[v].r, 200, "done_wait");
            @(negedge PCLK);
            chk("vec_queue_empty", exp_q.size(), 32'd0);
        end

        // Simultaneous requests, twice: grants alternate 0,1,0,1.
        set_req(0, 3'd1, 8'd1, 8'h11, 8'h00, 8'h00);
        set_req(1, 3'd3, 8'd1, 8'h22, 8'h00, 8'h00);
        for (int rnd = 0; rnd < 2; rnd++) begin
            push_txn(0, 8'h02, 1, 8'h11, 8'h00, 8'h00);
            push_txn(1, 8'h08, 1, 8'h22, 8'h00, 8'h00);
            @(posedge PCLK);
            #1;
            fork
                hold_req(0, 20);
                hold_req(1, 200);
            join
            wait_bit(1, 1, 200, "rr_done_wait");
            @(negedge PCLK);
            chk("rr_queue_empty", exp_q.size(), 32'd0);
        end

        // SPIRXAVAIL never rises: abort after the timeout window.
        rxavail_en = 1'b0;
        set_req(0, 3'd6, 8'd2, 8'h99, 8'h98, 8'h00);
        push_ev(KGnt, 0, 0);
        push_ev(KWr, 'h24, 'h40);
        push_ev(KWr, 'h0C, 'h99);
        push_ev(KTxAck, 0, 0);
        push_ev(KWr, 'h24, 'h00);
        push_ev(KDone, 0, 1);
        @(posedge PCLK);
        #1;
        hold_req(0, 20);
        wait_bit(2, 0, 50, "timeout_txack_wait");
        n = 0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge PCLK);
            n++;
            if (M_PSEL) break;
        end
        chk("timeout_cycles", n, 32'd1026);
        wait_bit(1, 0, 50, "timeout_done_wait");
        @(negedge PCLK);
        chk("timeout_queue_empty", exp_q.size(), 32'd0);
        rxavail_en = 1'b1;

        // Five wait states on the TXDATA write.
        stall_tx = 5;
        set_req(1, 3'd4, 8'd1, 8'h77, 8'h00, 8'h00);
        push_txn(1, 8'h10, 1, 8'h77, 8'h00, 8'h00);
        acc0 = tx_acc;
        @(posedge PCLK);
        #1;
        hold_req(1, 20);
        wait_bit(1, 1, 200, "stall_done_wait");
        chk("stall_access_cycles", tx_acc - acc0, 32'd6);
        @(negedge PCLK);
        chk("stall_queue_empty", exp_q.size(), 32'd0);
        stall_tx = 0;

        // Reset while waiting for RX: no done, init reruns.
        rxavail_en = 1'b0;
        set_req(0, 3'd3, 8'd1, 8'h5E, 8'h00, 8'h00);
        push_ev(KGnt, 0, 0);
        push_ev(KWr, 'h24, 'h08);
        push_ev(KWr, 'h0C, 'h5E);
        push_ev(KTxAck, 0, 0);
        @(posedge PCLK);
        #1;
        hold_req(0, 20);
        wait_bit(2, 0, 50, "rst_txack_wait");
        repeat (5) @(negedge PCLK);
        @(posedge PCLK);
        #1;
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("midrst_outputs", {M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA, req_ready,
                               tx_ack, rx_valid, done, err, rx_data}, 32'd0);
        chk("midrst_queue_empty", exp_q.size(), 32'd0);
        push_ev(KWr, 'h00, 'h03);
        push_ev(KWr, 'h24, 'h00);
        rxavail_en = 1'b1;
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        count_busy(n);
        chk("reinit_cycles", n, 32'd4);

        // Normal transaction after the re-init.
        set_req(1, 3'd1, 8'd1, 8'h42, 8'h00, 8'h00);
        push_txn(1, 8'h02, 1, 8'h42, 8'h00, 8'h00);
        @(posedge PCLK);
        #1;
        hold_req(1, 20);
        wait_bit(1, 1, 200, "post_rst_done_wait");
        repeat (2) @(negedge PCLK);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
